// File: rtl/dc_download_assembler.sv
// dc_download_assembler
//   Receive-side assembly stage for the data-cache port of a ring node.
//   Packs 16-bit flits (head/body/tail) into one 144-bit message. It offers
//   the message to the data-cache arbiter and holds it until the cache access
//   is reported done. At most one message is held at a time, and the ring
//   input is back-pressured while a message is pending.
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   v_flit_in                : incoming flit valid
//   flit_in [FLIT_W]         : flit payload
//   ctrl_in [2]              : 01 head, 10 body, 11 tail, 00 illegal
//   rdy_flit_in              : block can accept a flit this cycle
//   v_dc_download            : a complete message is offered
//   dc_download_flits [144]  : assembled message, first flit in the MSBs
//   re_dc_download_flits     : arbiter is reading the message
//   dc_download_done_access  : cache access for the message is complete
//   err_frame                : one-cycle pulse on a framing error
`timescale 1ns/1ps
module dc_download_assembler #(
  parameter int FLIT_W    = 16,
  parameter int MAX_FLITS = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        v_flit_in,
  input  logic [FLIT_W-1:0]           flit_in,
  input  logic [1:0]                  ctrl_in,
  output logic                        rdy_flit_in,
  output logic                        v_dc_download,
  output logic [FLIT_W*MAX_FLITS-1:0] dc_download_flits,
  input  logic                        re_dc_download_flits,
  input  logic                        dc_download_done_access,
  output logic                        err_frame
);

  localparam int BUF_W = FLIT_W * MAX_FLITS;
  localparam int CNT_W = $clog2(MAX_FLITS + 1);

  localparam logic [1:0] CTRL_ILLEGAL = 2'b00;
  localparam logic [1:0] CTRL_HEAD    = 2'b01;
  localparam logic [1:0] CTRL_BODY    = 2'b10;
  localparam logic [1:0] CTRL_TAIL    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ASSEMBLE = 2'b01,
    ST_FULL     = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic               err_q, err_d;
  logic               accept_s;

  // Return b with flit f written into slot idx (slot 0 = MSBs).
  function automatic logic [BUF_W-1:0] put_flit(
    input logic [BUF_W-1:0]  b,
    input logic [CNT_W-1:0]  idx,
    input logic [FLIT_W-1:0] f
  );
    logic [BUF_W-1:0] r;
    r = b;
    for (int i = 0; i < MAX_FLITS; i++) begin
      if (idx == CNT_W'(i)) begin
        r[BUF_W-1-FLIT_W*i -: FLIT_W] = f;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign accept_s = v_flit_in && (state_q != ST_FULL);

  // Next-state logic: framing, packing and release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (ctrl_in == CTRL_HEAD) begin
            buf_d   = put_flit({BUF_W{1'b0}}, {CNT_W{1'b0}}, flit_in);
            cnt_d   = CNT_W'(1);
            state_d = ST_ASSEMBLE;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          err_d = 1'b0;
        end
      end
      ST_ASSEMBLE: begin
        if (accept_s) begin
          case (ctrl_in)
            CTRL_HEAD: begin
              // Restart on a fresh head; the partial message is dropped.
              err_d = 1'b1;
              buf_d = put_flit({BUF_W{1'b0}}, {CNT_W{1'b0}}, flit_in);
              cnt_d = CNT_W'(1);
            end
            CTRL_BODY: begin
              buf_d = put_flit(buf_q, cnt_q, flit_in);
              cnt_d = cnt_q + CNT_W'(1);
              // Body in the last slot: truncate the over-length message.
              if (cnt_q == CNT_W'(MAX_FLITS - 1)) begin
                err_d   = 1'b1;
                state_d = ST_FULL;
              end else begin
                err_d = 1'b0;
              end
            end
            CTRL_TAIL: begin
              buf_d   = put_flit(buf_q, cnt_q, flit_in);
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = ST_FULL;
            end
            CTRL_ILLEGAL: begin
              err_d = 1'b1;
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end else begin
          err_d = 1'b0;
        end
      end
      ST_FULL: begin
        // Only a done that coincides with the arbiter's read releases the message.
        if (dc_download_done_access && re_dc_download_flits) begin
          buf_d   = {BUF_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        buf_d   = {BUF_W{1'b0}};
      end
    endcase
  end

  // State, counter, message buffer and error pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      buf_q   <= {BUF_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  assign rdy_flit_in       = (state_q != ST_FULL);
  assign v_dc_download     = (state_q == ST_FULL);
  assign dc_download_flits = buf_q;
  assign err_frame         = err_q;

endmodule

// File: tb/tb_dc_download_assembler.sv
`timescale 1ns/1ps
module tb_dc_download_assembler;

  localparam logic [1:0] ILL  = 2'b00;
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] BODY = 2'b10;
  localparam logic [1:0] TAIL = 2'b11;

  logic         clk;
  logic         rst;
  logic         v_flit_in;
  logic [15:0]  flit_in;
  logic [1:0]   ctrl_in;
  logic         rdy_flit_in;
  logic         v_dc_download;
  logic [143:0] dc_download_flits;
  logic         re_dc_download_flits;
  logic         dc_download_done_access;
  logic         err_frame;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: flits of the message in progress or held, plus a held flag.
  logic [15:0] m_q[$];
  bit          m_full;
  bit          m_err;

  dc_download_assembler #(.FLIT_W(16), .MAX_FLITS(9)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .v_flit_in               (v_flit_in),
    .flit_in                 (flit_in),
    .ctrl_in                 (ctrl_in),
    .rdy_flit_in             (rdy_flit_in),
    .v_dc_download           (v_dc_download),
    .dc_download_flits       (dc_download_flits),
    .re_dc_download_flits    (re_dc_download_flits),
    .dc_download_done_access (dc_download_done_access),
    .err_frame               (err_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] model_msg();
    logic [143:0] m;
    m = 144'h0;
    foreach (m_q[i]) m[143-16*i -: 16] = m_q[i];
    return m;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_full = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".rdy"},   {143'h0, rdy_flit_in},   {143'h0, !m_full});
    check_eq({tag, ".v"},     {143'h0, v_dc_download}, {143'h0, m_full});
    check_eq({tag, ".err"},   {143'h0, err_frame},     {143'h0, m_err});
    check_eq({tag, ".flits"}, dc_download_flits,       model_msg());
  endtask

  // One clock: drive inputs (at negedge), advance the model, check at next negedge.
  task automatic step(input string tag, input bit v, input logic [15:0] f, input logic [1:0] c,
                      input bit done, input bit re);
    v_flit_in = v; flit_in = f; ctrl_in = c;
    dc_download_done_access = done; re_dc_download_flits = re;
    m_err = 1'b0;
    if (m_full) begin
      if (done && re) begin
        m_full = 1'b0;
        m_q.delete();
      end
    end else if (v) begin
      if (m_q.size() == 0) begin
        if (c == HEAD) m_q.push_back(f);
        else m_err = 1'b1;
      end else begin
        case (c)
          HEAD: begin m_err = 1'b1; m_q.delete(); m_q.push_back(f); end
          BODY: begin
            m_q.push_back(f);
            if (m_q.size() == 9) begin m_err = 1'b1; m_full = 1'b1; end
          end
          TAIL: begin m_q.push_back(f); m_full = 1'b1; end
          default: m_err = 1'b1;
        endcase
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    v_flit_in = 1'b0; flit_in = 16'h0; ctrl_in = ILL;
    dc_download_done_access = 1'b0; re_dc_download_flits = 1'b0;
  endtask

  // Pulse reset between clock edges and check outputs before any edge arrives.
  task automatic async_reset(input string tag);
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    rst = 1'b0;
    @(negedge clk);
    check_outputs({tag, ".after"});
  endtask

  initial begin
    int err_cnt;
    idle_inputs();
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // 3-flit request
    step("h3", 1'b1, 16'hA001, HEAD, 1'b0, 1'b0);
    step("b3", 1'b1, 16'h1234, BODY, 1'b0, 1'b0);
    step("t3", 1'b1, 16'h5678, TAIL, 1'b0, 1'b0);
    check_eq("msg3", dc_download_flits, {16'hA001, 16'h1234, 16'h5678, 96'h0});
    check_eq("msg3.v", {143'h0, v_dc_download}, 144'h1);
    check_eq("msg3.rdy", {143'h0, rdy_flit_in}, 144'h0);

    // Hold: flits refused and done without re ignored
    for (int i = 0; i < 5; i++) step("hold", 1'b1, 16'hDEAD, BODY, 1'b1, 1'b0);
    check_eq("hold.msg", dc_download_flits, {16'hA001, 16'h1234, 16'h5678, 96'h0});
    // Release cycle also offers a flit; it must not be taken
    step("rel", 1'b1, 16'hBEEF, HEAD, 1'b1, 1'b1);
    check_eq("rel.flits", dc_download_flits, 144'h0);
    check_eq("rel.rdy", {143'h0, rdy_flit_in}, 144'h1);

    // 9-flit reply
    err_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      step("r9", 1'b1, 16'h1000 + 16'(k), (k == 0) ? HEAD : ((k == 8) ? TAIL : BODY), 1'b0, 1'b0);
      if (err_frame) err_cnt++;
    end
    check_eq("msg9", dc_download_flits, {16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004,
                                         16'h1005, 16'h1006, 16'h1007, 16'h1008});
    check_eq("msg9.err", 144'(err_cnt), 144'h0);
    step("rel9", 1'b0, 16'h0, ILL, 1'b1, 1'b1);

    // Body in IDLE
    step("idlebody", 1'b1, 16'h7777, BODY, 1'b0, 1'b0);
    check_eq("idlebody.err", {143'h0, err_frame}, 144'h1);
    step("idlebody2", 1'b0, 16'h0, ILL, 1'b0, 1'b0);

    // Head, body, head, tail
    step("hh1", 1'b1, 16'h1111, HEAD, 1'b0, 1'b0);
    step("hh2", 1'b1, 16'h2222, BODY, 1'b0, 1'b0);
    step("hh3", 1'b1, 16'hB000, HEAD, 1'b0, 1'b0);
    check_eq("hh3.err", {143'h0, err_frame}, 144'h1);
    step("hh4", 1'b1, 16'hC000, TAIL, 1'b0, 1'b0);
    check_eq("hh.msg", dc_download_flits, {16'hB000, 16'hC000, 112'h0});
    step("hhrel", 1'b0, 16'h0, ILL, 1'b1, 1'b1);

    // Over-length: head + 8 bodies, then a refused 10th flit
    for (int k = 0; k < 9; k++) step("ovl", 1'b1, 16'h2000 + 16'(k), (k == 0) ? HEAD : BODY, 1'b0, 1'b0);
    check_eq("ovl.err", {143'h0, err_frame}, 144'h1);
    check_eq("ovl.v", {143'h0, v_dc_download}, 144'h1);
    check_eq("ovl.last", {128'h0, dc_download_flits[15:0]}, 144'h2008);
    step("ovl10", 1'b1, 16'h2009, BODY, 1'b0, 1'b0);
    check_eq("ovl10.rdy", {143'h0, rdy_flit_in}, 144'h0);
    step("ovlrel", 1'b0, 16'h0, ILL, 1'b1, 1'b1);

    // Asynchronous reset in ASSEMBLE and in FULL
    step("ar1", 1'b1, 16'h3000, HEAD, 1'b0, 1'b0);
    step("ar2", 1'b1, 16'h3001, BODY, 1'b0, 1'b0);
    async_reset("rst_asm");
    step("ar3", 1'b1, 16'h4000, HEAD, 1'b0, 1'b0);
    step("ar4", 1'b1, 16'h4001, TAIL, 1'b0, 1'b0);
    async_reset("rst_full");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [1:0] c;
      r = $urandom_range(0, 99);
      c = (r < 12) ? HEAD : (r < 75) ? BODY : (r < 93) ? TAIL : ILL;
      step("rand", ($urandom_range(0, 9) < 8), 16'($urandom), c,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dc_download_assembler.md
# dc_download_assembler

Receive-side assembly stage for the data-cache port of a ring node. It takes 16-bit flits arriving from the node's IN request/reply path and packs one complete message into a 144-bit register. It then offers that message to the data-cache arbiter through the `v_dc_download` / `dc_download_flits` pair, and holds it there until the arbiter reports that the cache access has finished. It holds at most one message at a time and back-pressures the ring input while a message is pending.

## Interface
Parameters:
- `FLIT_W`, 16: width of one incoming flit.
- `MAX_FLITS`, 9: maximum flits per message; `FLIT_W*MAX_FLITS` must equal 144.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `v_flit_in`, in, 1: an incoming flit is valid this cycle.
- `flit_in`, in, 16: flit payload.
- `ctrl_in`, in, 2: flit type. 2'b01 = head, 2'b10 = body, 2'b11 = tail, 2'b00 = illegal.
- `rdy_flit_in`, out, 1: block accepts a flit this cycle. A flit transfers when `v_flit_in && rdy_flit_in` at a rising edge.
- `v_dc_download`, out, 1: a complete message is held and offered to the arbiter.
- `dc_download_flits`, out, 144: the assembled message.
- `re_dc_download_flits`, in, 1: the arbiter is currently reading the message.
- `dc_download_done_access`, in, 1: the cache access for the offered message is complete.
- `err_frame`, out, 1: one-cycle pulse on any framing error.

## Operation
- State register `state` with three encodings: IDLE, ASSEMBLE, FULL. Plus `cnt` (4 bits, range 0..9) and `buf` (144 bits).
- Packing rule: the flit accepted when `cnt == i` is written to `buf[143-16*i -: 16]`.
  - The first flit lands in the MSBs.
  - Slots not written stay 0.
  - `cnt` increments on every stored flit.
- Outputs:
  - `rdy_flit_in` is 1 in IDLE and ASSEMBLE, 0 in FULL.
  - `v_dc_download` is 1 only in FULL.
  - `dc_download_flits` = `buf` at all times. It is stable throughout FULL.
- IDLE:
  - Accepted head: clear `buf`, store the flit in slot 0, set `cnt` = 1, go to ASSEMBLE.
  - Accepted body, tail or illegal flit: discard it, pulse `err_frame`, stay in IDLE.
- ASSEMBLE:
  - Accepted body: store it and increment `cnt`.
  - Accepted tail: store it and go to FULL.
  - Accepted head: framing error. Pulse `err_frame`, clear `buf`, store the new head in slot 0, set `cnt` = 1, stay in ASSEMBLE. The partial message is lost.
  - Accepted illegal flit: discard it and pulse `err_frame`.
  - Length limit: a body accepted while `cnt == 8` is stored in slot 8, pulses `err_frame`, and forces FULL. This is an over-length message truncated to 9 flits. A tail at `cnt == 8` is a normal 9-flit message.
- FULL:
  - On `dc_download_done_access && re_dc_download_flits`: clear `buf` to 0, set `cnt` = 0, go to IDLE.
  - `dc_download_done_access` without `re_dc_download_flits` is ignored.
  - No flit is accepted in FULL, including in the release cycle. There is no same-cycle bypass.
- `v_flit_in` with `rdy_flit_in` = 0: no effect. The sender must hold the flit.

## Timing
- Reset, asynchronous and immediate: state IDLE, `cnt` = 0, `buf` = 0. Therefore `rdy_flit_in` = 1, `v_dc_download` = 0, `dc_download_flits` = 0, `err_frame` = 0.
- Reset asserted mid-message or in FULL discards the message. No done is expected afterwards.
- Latency: tail accepted at edge N gives `v_dc_download` = 1 and `rdy_flit_in` = 0 from just after edge N.
- Release: done && re sampled at edge M gives `v_dc_download` = 0 and `rdy_flit_in` = 1 just after edge M. The first new flit can transfer at edge M+1.
- Throughput: one flit per cycle while assembling. Minimum message turnaround is message length + 1 cycle + the arbiter's service time.
- `err_frame` is registered: high for exactly the one cycle following the offending edge.
- All outputs are driven from registered state. There is no combinational path from any input to `v_dc_download` or `dc_download_flits`.

## Test plan
- 3-flit request: head 16'hA001, body 16'h1234, tail 16'h5678 on consecutive cycles.
  - `v_dc_download` rises the cycle after the tail.
  - `dc_download_flits` = {16'hA001, 16'h1234, 16'h5678, 96'h0}.
  - `rdy_flit_in` = 0 in that same cycle.
- 9-flit reply: flit k = 16'h1000+k, with k=8 as the tail. Result is `dc_download_flits` = {16'h1000, …, 16'h1008}. `err_frame` stays 0.
- Hold and release:
  - In FULL, drive `v_flit_in` = 1 for 5 cycles and assert `dc_download_done_access` with `re_dc_download_flits` = 0. The message is unchanged and `v_dc_download` stays 1.
  - Then assert done and re together for one cycle. On the next cycle `v_dc_download` = 0, `dc_download_flits` = 0 and `rdy_flit_in` = 1.
- Framing errors:
  - Body in IDLE: one `err_frame` pulse, state stays IDLE.
  - Head, body, then head 16'hB000, then tail 16'hC000: one `err_frame` pulse. Result is {16'hB000, 16'hC000, 112'h0}.
- Over-length message: head plus 8 bodies gives `err_frame` on the 9th flit and FULL with 9 flits. A 10th flit is refused (`rdy_flit_in` = 0).
- Asynchronous reset: assert `rst` between clock edges in ASSEMBLE and again in FULL. Outputs return to reset values immediately, without waiting for a clock edge.
